// File: rtl/apb_wdt.sv
`default_nettype none
// ============================================================================
// Module   : apb_wdt
// Brief    : APB watchdog with key-protected config, two-stage expiry
//            (interrupt, then reset-request pulse).
// Revision : 1.0 - initial release
// ============================================================================
module apb_wdt #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int PRESCALE       = 1,
    parameter int RST_PULSE      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      irq_o,
    output logic                      rst_req_o
);

    localparam logic [31:0] c_kick_key   = 32'h5A5A_A5A5;
    localparam logic [31:0] c_unlock_key = 32'h1ACC_E551;
    localparam logic [15:0] c_presc_max  = 16'(PRESCALE - 1);
    localparam int          c_pulse_w    = $clog2(RST_PULSE + 1);
    localparam logic [c_pulse_w-1:0] c_pulse_len = c_pulse_w'(RST_PULSE);

    localparam logic [2:0] c_off_ctrl   = 3'd0;
    localparam logic [2:0] c_off_load   = 3'd1;
    localparam logic [2:0] c_off_count  = 3'd2;
    localparam logic [2:0] c_off_kick   = 3'd3;
    localparam logic [2:0] c_off_lock   = 3'd4;
    localparam logic [2:0] c_off_status = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WARN = 2'd1,
        ST_BITE = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_ctrl;
    logic [31:0]           r_load;
    logic [31:0]           r_count, w_count_nxt;
    logic                  r_locked;
    logic                  r_irq_pend;
    logic                  r_expired;
    logic [15:0]           r_presc;
    logic [c_pulse_w-1:0]  r_pulse;

    logic        w_access, w_wr, w_rd;
    logic [2:0]  w_off;
    logic        w_err;
    logic [31:0] w_prdata;
    logic        w_ctrl_we, w_load_we, w_lock_we, w_stat_we;
    logic        w_kick, w_en_rise, w_en_fall, w_tick;
    logic        w_irq_clr, w_exp_clr;
    logic        w_irq_set, w_exp_set, w_pulse_start;
    logic        w_unused;

    assign w_unused = ^{paddr[APB_ADDR_WIDTH-1:5], paddr[1:0]};

    assign w_access = psel & penable;
    assign w_wr     = w_access & pwrite;
    assign w_rd     = w_access & ~pwrite;
    assign w_off    = paddr[4:2];

    // Read mux and error decode; both are purely combinational.
    always_comb begin
        w_err    = 1'b0;
        w_prdata = 32'd0;
        case (w_off)
            c_off_ctrl: begin
                if (w_wr && r_locked) w_err = 1'b1;
                if (w_rd) w_prdata = {29'd0, r_ctrl};
            end
            c_off_load: begin
                if (w_wr && r_locked) w_err = 1'b1;
                if (w_rd) w_prdata = r_load;
            end
            c_off_count: begin
                if (w_wr) w_err = 1'b1;
                if (w_rd) w_prdata = r_count;
            end
            c_off_kick: begin
                if (w_wr && (pwdata != c_kick_key)) w_err = 1'b1;
            end
            c_off_lock: begin
                if (w_rd) w_prdata = {31'd0, r_locked};
            end
            c_off_status: begin
                if (w_rd) w_prdata = {30'd0, r_expired, r_irq_pend};
            end
            default: begin
                if (w_access) w_err = 1'b1;
            end
        endcase
    end

    assign prdata  = w_prdata;
    assign pslverr = w_err;
    assign pready  = 1'b1;

    assign w_ctrl_we = w_wr & (w_off == c_off_ctrl) & ~r_locked;
    assign w_load_we = w_wr & (w_off == c_off_load) & ~r_locked;
    assign w_lock_we = w_wr & (w_off == c_off_lock);
    assign w_stat_we = w_wr & (w_off == c_off_status);
    // A kick has no effect once bitten; only reset or disable leaves BITE.
    assign w_kick    = w_wr & (w_off == c_off_kick) & (pwdata == c_kick_key)
                     & (r_state != ST_BITE);
    assign w_irq_clr = w_stat_we & pwdata[0];
    assign w_exp_clr = w_stat_we & pwdata[1];
    assign w_en_rise = w_ctrl_we & pwdata[0] & ~r_ctrl[0];
    assign w_en_fall = w_ctrl_we & ~pwdata[0] & r_ctrl[0];
    assign w_tick    = r_ctrl[0] & (r_presc == c_presc_max);

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_irq_set     = 1'b0;
        w_exp_set     = 1'b0;
        w_pulse_start = 1'b0;
        if (w_en_fall) begin
            w_state_nxt = ST_RUN;
        end else if (w_kick) begin
            w_count_nxt = r_load;
            w_state_nxt = ST_RUN;
        end else if (w_en_rise) begin
            w_count_nxt = r_load;
        end else if (w_tick) begin
            case (r_state)
                ST_RUN: begin
                    if (r_count != 32'd0) begin
                        w_count_nxt = r_count - 32'd1;
                    end else begin
                        w_irq_set   = 1'b1;
                        w_count_nxt = r_load;
                        w_state_nxt = ST_WARN;
                    end
                end
                ST_WARN: begin
                    if (r_count != 32'd0) begin
                        w_count_nxt = r_count - 32'd1;
                    end else if (r_irq_pend) begin
                        w_exp_set     = 1'b1;
                        w_state_nxt   = ST_BITE;
                        w_pulse_start = r_ctrl[2];
                    end else begin
                        w_irq_set   = 1'b1;
                        w_count_nxt = r_load;
                    end
                end
                default: ;
            endcase
        end
        // Acknowledging the interrupt re-arms the first stage.
        if (w_irq_clr && !w_irq_set && (w_state_nxt == ST_WARN)) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_ctrl     <= 3'd0;
            r_load     <= 32'hFFFF_FFFF;
            r_count    <= 32'hFFFF_FFFF;
            r_locked   <= 1'b1;
            r_irq_pend <= 1'b0;
            r_expired  <= 1'b0;
            r_presc    <= 16'd0;
            r_pulse    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_ctrl_we) r_ctrl <= pwdata[2:0];
            if (w_load_we) r_load <= pwdata;
            if (w_lock_we) r_locked <= (pwdata != c_unlock_key);

            if (w_irq_set)      r_irq_pend <= 1'b1;
            else if (w_irq_clr) r_irq_pend <= 1'b0;
            if (w_exp_set)      r_expired <= 1'b1;
            else if (w_exp_clr) r_expired <= 1'b0;

            if (w_en_rise || w_kick)
                r_presc <= 16'd0;
            else if (r_ctrl[0])
                r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;

            if (w_pulse_start)
                r_pulse <= c_pulse_len;
            else if (r_pulse != '0)
                r_pulse <= r_pulse - c_pulse_w'(1);
        end
    end

    assign irq_o     = r_irq_pend & r_ctrl[1];
    assign rst_req_o = (r_pulse != '0);

endmodule
`default_nettype wire

// File: doc/apb_wdt.md
# apb_wdt

APB watchdog timer slave that sits on one `psel` lane of the AXI-to-APB bridge output bus and consumes its APB transfers. It holds a key-protected down-counter with a two-stage expiry. On the first timeout it raises an interrupt and reloads. On the second timeout, if the interrupt is still pending, it pulses a system reset request. All APB accesses complete with zero wait states; only error signalling uses `pslverr`.

## Interface
- `APB_ADDR_WIDTH`, default 12: width of `paddr`. Only `paddr[4:2]` is decoded.
- `PRESCALE`, default 1: clock cycles per counter tick. Legal range 1..65535.
- `RST_PULSE`, default 16: `rst_req_o` pulse length in cycles, ≥1.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: synchronous active-high reset.
- `psel` in, 1: slave select.
- `penable` in, 1: access phase.
- `pwrite` in, 1: 1 = write.
- `paddr` in, `APB_ADDR_WIDTH`: byte address.
- `pwdata` in, 32: write data.
- `prdata` out, 32: read data.
- `pready` out, 1: transfer ready.
- `pslverr` out, 1: transfer error.
- `irq_o` out, 1: interrupt, level.
- `rst_req_o` out, 1: reset request pulse.

## Operation
- Register map (offset: register):
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 RST_EN. Write is key-protected.
  - 0x04 LOAD: 32-bit reload value. Write is key-protected.
  - 0x08 COUNT: read-only current count.
  - 0x0C KICK: write 0x5A5AA5A5 to reload.
  - 0x10 LOCK: write 0x1ACCE551 to unlock; any other write value locks. Read returns bit0 = locked.
  - 0x14 STATUS: bit0 IRQ_PEND, bit1 EXPIRED. Both bits are write-1-to-clear and are never locked.
  - 0x18–0x1C: unmapped.
- A transfer completes in the cycle where `psel & penable` holds. Writes update state at the end of that cycle.
- Error responses:
  - `pslverr`=1 with no state change for: a CTRL/LOAD write while locked; a KICK write of any other value; any write to COUNT; any access to an unmapped offset.
  - Unmapped reads return 0.
- Enable and prescaler:
  - A CTRL write taking EN 0→1 loads COUNT←LOAD and clears the prescaler.
  - When EN=0, the counter and prescaler hold.
  - The prescaler counts 0..PRESCALE-1. A tick occurs at PRESCALE-1, after which the prescaler returns to 0.
- State machine (EN=1, evaluated on each tick):
  - RUN, COUNT≠0: COUNT decrements by 1.
  - RUN, COUNT==0: IRQ_PEND←1, COUNT←LOAD, go to WARN.
  - WARN, COUNT≠0: COUNT decrements by 1.
  - WARN, COUNT==0, IRQ_PEND=1: EXPIRED←1, COUNT holds at 0, go to BITE. If RST_EN=1, start the reset pulse.
  - WARN, COUNT==0, IRQ_PEND=0: treated as the RUN expiry again (set IRQ_PEND, reload, stay in WARN).
  - A valid KICK, or clearing IRQ_PEND, moves WARN back to RUN. A valid KICK also reloads COUNT←LOAD and clears the prescaler.
  - BITE is exited only by `rst_i` or by EN 1→0. EN 1→0 goes to RUN.
- Simultaneous events:
  - A valid KICK in the same cycle as a tick with COUNT==0: the KICK wins and no expiry occurs.
  - A W1C write in the same cycle that sets a STATUS bit: the set wins.
- Outputs:
  - `irq_o` = IRQ_PEND & IRQ_EN.
  - `rst_req_o` is high for exactly RST_PULSE cycles, then low, even if the block stays in BITE.

## Timing
- Reset values:
  - Outputs: `prdata`=0, `pslverr`=0, `irq_o`=0, `rst_req_o`=0.
  - State: CTRL=0, LOAD=0xFFFFFFFF, COUNT=0xFFFFFFFF, locked=1, STATUS=0, prescaler=0, state RUN.
- `pready` is tied to 1, giving zero wait states.
- `prdata` and `pslverr` are combinational from registers and decode, valid during the access phase. `prdata`=0 when not reading.
- A write's effect is visible to a read in the following transfer. COUNT reads return the pre-tick value in the tick cycle.
- `irq_o` rises the cycle after the tick that sets IRQ_PEND.
- `rst_req_o` rises the cycle after the tick that enters BITE.
- `rst_i` mid-pulse terminates `rst_req_o` at the next edge.
- COUNT arithmetic is unsigned 32-bit and never wraps below 0.
- With LOAD=0, expiry occurs on every tick.

## Test plan
- Reset, then read LOCK → 1. Write CTRL=0x7 → `pslverr`=1 and CTRL reads 0.
- Write LOCK=0x1ACCE551, LOAD=3, CTRL=0x7 with PRESCALE=1. Expect COUNT reads 3,2,1,0 on successive ticks; `irq_o`=1 one cycle after the 0-tick; COUNT=3 again.
- Continue with no kick. After 4 more ticks expect EXPIRED=1 and `rst_req_o` high for exactly 16 cycles, then 0; COUNT holds at 0.
- In WARN, write KICK=0x5A5AA5A5 on the same cycle COUNT==0 ticks → no reset pulse and COUNT=3. Write KICK=0x12345678 → `pslverr`=1 and no reload.
- Write STATUS=0x1 while locked → IRQ_PEND clears, `irq_o`=0, no error. Read 0x18 → `prdata`=0, `pslverr`=1.
- Assert `rst_i` 5 cycles into the reset pulse → `rst_req_o`=0 next cycle and all registers return to their reset values.
